// File: rtl/preset_timer_pkg.sv
// Shared encodings for the preset timer: terminal modes, direction and run state.
package preset_timer_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_FREE    = 2'd0;
  localparam mode_t MODE_RELOAD  = 2'd1;
  localparam mode_t MODE_ONESHOT = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Run state: ST_DONE is entered only on one-shot expiry and left only by preset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } run_state_t;

endpackage : preset_timer_pkg

// File: rtl/preset_timer_if.sv
// Control and status bundle between a timer user (master) and the timer (slave).
interface preset_timer_if
  import preset_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);

  logic                  enable;
  logic                  preset;
  logic [WIDTH-1:0]      preset_input;
  logic                  dir;
  mode_t                 mode;
  logic [PRESCALE_W-1:0] prescale_div;
  logic [WIDTH-1:0]      count_out;
  logic                  tpulse;
  logic                  running;

  modport master (
    output enable, preset, preset_input, dir, mode, prescale_div,
    input  count_out, tpulse, running
  );

  modport slave (
    input  enable, preset, preset_input, dir, mode, prescale_div,
    output count_out, tpulse, running
  );

endinterface : preset_timer_if

// File: rtl/timer_prescaler.sv
// Clock prescaler: asserts tick on every (div+1)-th advancing cycle.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_d;

  // A div lowered below pre_q is not caught here; pre_q wraps through zero first.
  assign tick = advance && (pre_q == div);

  // Next prescaler value: clear wins, otherwise count while advancing, return to 0 on tick.
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (advance) begin
      pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : timer_prescaler

// File: rtl/preset_timer.sv
// Parameterised preset timer: up/down count, prescaler, free-run/reload/one-shot terminal modes.
module preset_timer
  import preset_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  preset_timer_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tpulse_q, tpulse_d;
  run_state_t       state_q, state_d;

  logic             running_c;
  logic             advance_c;
  logic             tick_c;
  logic [WIDTH-1:0] terminal_c;
  logic             at_term_c;

  assign running_c  = (state_q == ST_RUN);
  assign advance_c  = bus.enable && running_c;
  assign terminal_c = (bus.dir == DIR_DOWN) ? '0 : '1;
  assign at_term_c  = (count_q == terminal_c);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.preset),
    .advance (advance_c),
    .div     (bus.prescale_div),
    .tick    (tick_c)
  );

  // Next count, reload value, pulse and run state; preset overrides any same-cycle tick.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tpulse_d = 1'b0;
    state_d  = state_q;
    if (bus.preset) begin
      count_d  = bus.preset_input;
      reload_d = bus.preset_input;
      state_d  = ST_RUN;
    end else if (tick_c) begin
      if (!at_term_c) begin
        count_d = (bus.dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
      end else begin
        tpulse_d = 1'b1;
        case (bus.mode)
          MODE_RELOAD:  count_d = reload_q;
          MODE_ONESHOT: state_d = ST_DONE;
          default:      count_d = (bus.dir == DIR_DOWN) ? '1 : '0;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      tpulse_q <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tpulse_q <= tpulse_d;
      state_q  <= state_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.tpulse    = tpulse_q;
  assign bus.running   = running_c;

endmodule : preset_timer

// File: tb/tb_preset_timer.sv
// Directed bench for preset_timer with a queue of expected per-cycle outputs.
module tb_preset_timer;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PRESCALE_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             tp;
    logic             run;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  preset_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  preset_timer #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_now(input string tag, input logic [WIDTH-1:0] c, input logic t, input logic r);
    chk({tag, ".count"},   bus.count_out, c);
    chk({tag, ".tpulse"},  WIDTH'(bus.tpulse), WIDTH'(t));
    chk({tag, ".running"}, WIDTH'(bus.running), WIDTH'(r));
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic step(input string tag, input logic [WIDTH-1:0] c, input logic t, input logic r);
    exp_t e;
    e.cnt = c;
    e.tp  = t;
    e.run = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_now(tag, e.cnt, e.tp, e.run);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.enable       = 1'b1;
    bus.preset       = 1'b0;
    bus.preset_input = '0;
    bus.dir          = 1'b0;
    bus.mode         = 2'd0;
    bus.prescale_div = '0;
    #2;
    chk_now("reset", 8'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Free-run up from 250, wrap with pulse, then a full 256-cycle period.
    bus.preset = 1'b1; bus.preset_input = 8'd250;
    step("t1_preset", 8'd250, 1'b0, 1'b1);
    bus.preset = 1'b0;
    for (int i = 251; i <= 255; i++) step("t1_up", WIDTH'(i), 1'b0, 1'b1);
    step("t1_wrap", 8'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 255; i++) step("t1_period", WIDTH'(i), 1'b0, 1'b1);
    step("t1_wrap2", 8'd0, 1'b1, 1'b1);

    // Auto-reload counting down from 5, period 6.
    bus.mode = 2'd1; bus.dir = 1'b1;
    bus.preset = 1'b1; bus.preset_input = 8'd5;
    step("t2_preset", 8'd5, 1'b0, 1'b1);
    bus.preset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 4; i >= 0; i--) step("t2_down", WIDTH'(i), 1'b0, 1'b1);
      step("t2_reload", 8'd5, 1'b1, 1'b1);
    end

    // One-shot up from 253: stop at 255, hold, then re-arm with preset.
    bus.mode = 2'd2; bus.dir = 1'b0;
    bus.preset = 1'b1; bus.preset_input = 8'd253;
    step("t3_preset", 8'd253, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t3_up", 8'd254, 1'b0, 1'b1);
    step("t3_up", 8'd255, 1'b0, 1'b1);
    step("t3_expire", 8'd255, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("t3_hold", 8'd255, 1'b0, 1'b0);
    bus.preset = 1'b1; bus.preset_input = 8'd100;
    step("t3_rearm", 8'd100, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t3_resume", 8'd101, 1'b0, 1'b1);
    step("t3_resume", 8'd102, 1'b0, 1'b1);

    // Prescale by 4 and enable freeze.
    bus.mode = 2'd0; bus.prescale_div = 4'd3;
    bus.preset = 1'b1; bus.preset_input = 8'd254;
    step("t4_preset", 8'd254, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t4_wait", 8'd254, 1'b0, 1'b1);
    step("t4_wait", 8'd254, 1'b0, 1'b1);
    step("t4_wait", 8'd254, 1'b0, 1'b1);
    step("t4_tick", 8'd255, 1'b0, 1'b1);
    step("t4_wait", 8'd255, 1'b0, 1'b1);
    step("t4_wait", 8'd255, 1'b0, 1'b1);
    step("t4_wait", 8'd255, 1'b0, 1'b1);
    step("t4_wrap", 8'd0, 1'b1, 1'b1);
    step("t4_wait", 8'd0, 1'b0, 1'b1);
    step("t4_wait", 8'd0, 1'b0, 1'b1);
    bus.enable = 1'b0;
    for (int i = 0; i < 7; i++) step("t4_frozen", 8'd0, 1'b0, 1'b1);
    bus.enable = 1'b1;
    step("t4_thaw", 8'd0, 1'b0, 1'b1);
    step("t4_thaw_tick", 8'd1, 1'b0, 1'b1);

    // Mode 3 behaves as free-run.
    bus.prescale_div = '0; bus.mode = 2'd3;
    bus.preset = 1'b1; bus.preset_input = 8'd255;
    step("t5_m3_preset", 8'd255, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t5_m3_wrap", 8'd0, 1'b1, 1'b1);

    // Down-count free-run wraps 0 -> 255.
    bus.mode = 2'd0; bus.dir = 1'b1;
    step("t5_down_wrap", 8'd255, 1'b1, 1'b1);
    bus.dir = 1'b0;

    // Preset colliding with a terminal tick wins and suppresses the pulse.
    bus.preset = 1'b1; bus.preset_input = 8'd254;
    step("t5_preset", 8'd254, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t5_up", 8'd255, 1'b0, 1'b1);
    bus.preset = 1'b1; bus.preset_input = 8'd42;
    step("t5_collide", 8'd42, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t5_after", 8'd43, 1'b0, 1'b1);

    // Asynchronous reset mid-count.
    bus.preset = 1'b1; bus.preset_input = 8'd127;
    step("t5_pre127", 8'd127, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t5_128", 8'd128, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1 chk_now("t5_async_rst", 8'd0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    step("t5_post_rst", 8'd1, 1'b0, 1'b1);

    // Asynchronous reset during a one-shot pulse.
    bus.mode = 2'd2;
    bus.preset = 1'b1; bus.preset_input = 8'd254;
    step("t5_os_preset", 8'd254, 1'b0, 1'b1);
    bus.preset = 1'b0;
    step("t5_os_up", 8'd255, 1'b0, 1'b1);
    step("t5_os_pulse", 8'd255, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 chk_now("t5_rst_pulse", 8'd0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    step("t5_post_rst2", 8'd1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_preset_timer

// File: doc/preset_timer.md
Name: preset_timer

Overview:
- Parameterised successor to the 8-bit preset/terminal-pulse counter.
- Adds generic width, up/down direction, a clock prescaler, a count enable, and three terminal modes: free-run, auto-reload and one-shot.
- Emits a single-cycle terminal pulse (tpulse) when the count passes its terminal value.
- Sits as a general timebase/event timer beside the existing counter tops; tpulse feeds interrupt or sequencing logic.

Parameters:
- WIDTH, 8, counter, preset and reload width in bits.
- PRESCALE_W, 4, width of the prescaler divide field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; when low, prescaler and counter hold.
- preset  input  1  synchronous load strobe.
- preset_input  input  WIDTH  value loaded on preset; also captured as the reload value.
- dir  input  1  0 = count up, 1 = count down.
- mode  input  2  0 = free-run, 1 = auto-reload, 2 = one-shot, 3 = treated as free-run.
- prescale_div  input  PRESCALE_W  counter advances once every prescale_div+1 enabled cycles.
- count_out  output  WIDTH  current count (registered).
- tpulse  output  1  terminal pulse, one clk wide.
- running  output  1  high while counting is permitted; low after a one-shot expiry.

Behaviour:
- Reset (asynchronous):
  - count = 0, reload_reg = 0, prescaler = 0.
  - tpulse = 0, running = 1.
- Tick:
  - tick = enable & running & (prescaler == prescale_div).
  - On enable & running, the prescaler increments; on tick it returns to 0.
  - With prescale_div = 0, tick = enable & running every cycle.
- Terminal value: all-ones when dir = 0; zero when dir = 1.
- On a tick, the action depends on whether count is at the terminal value:
  - count != terminal: count +1 (up) or -1 (down). No tpulse.
  - count == terminal, mode 0/3: wrap, up 2^WIDTH-1 -> 0, down 0 -> 2^WIDTH-1.
  - count == terminal, mode 1: count <= reload_reg.
  - count == terminal, mode 2: count holds and running <= 0.
  - In all three terminal cases, tpulse <= 1 for exactly the next cycle.
- tpulse is registered and rises at the same edge that applies the wrap/reload/stop. It is 0 on every other cycle.
- Preset (synchronous; highest priority after reset):
  - count <= preset_input, reload_reg <= preset_input.
  - prescaler <= 0, running <= 1, tpulse <= 0.
  - Any tick in the same cycle is discarded.
  - Preset works even when enable = 0 or running = 0.
- Changing dir mid-count takes effect at the next tick; the terminal value is evaluated with the current dir.
- Changing prescale_div below the current prescaler value: the prescaler continues counting and wraps at 2^PRESCALE_W before matching. This is allowed; no error is flagged.
- Auto-reload with reload_reg equal to the terminal value: tpulse fires on every tick.
- One-shot expiry:
  - count_out stays at the terminal value and running = 0.
  - Further ticks are suppressed and the prescaler freezes, until the next preset.
- Reset asserted mid-count or mid-pulse clears everything immediately. tpulse must never stretch across reset.
- Latency: preset-to-count_out 1 cycle; tick-to-count_out 1 cycle.

Decomposition:
- Package preset_timer_pkg holds:
  - mode encodings MODE_FREE = 2'd0, MODE_RELOAD = 2'd1, MODE_ONESHOT = 2'd2;
  - direction constants DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module timer_prescaler (PRESCALE_W):
  - inputs clk, reset, clear, advance, div; output tick.
  - Instantiated once, with clear = preset and advance = enable & running.
- Counter, terminal detection and mode logic stay in preset_timer.

Test Plan:
1. WIDTH = 8, mode 0, dir up, prescale_div 0, enable 1; preset with preset_input = 250 -> count_out 251, 252, 253, 254, 255 on the following edges, then 0 with tpulse = 1 for one cycle; next tpulse exactly 256 cycles later.
2. Mode 1, dir down, preset 5 -> count 4, 3, 2, 1, 0, then 5 with tpulse; tpulse period is 6 cycles.
3. Mode 2, dir up, preset 253 -> 254, 255, then one tpulse, count holds at 255 and running = 0; 20 further cycles give no change. A new preset of 100 restores running = 1 and counting resumes.
4. Prescale_div = 3, mode 0, preset 254 -> count advances every 4 cycles (255, then 0); tpulse coincides with the 0. Toggling enable low for 7 cycles freezes both count and prescaler.
5. Preset asserted in the same cycle as a terminal tick (count 255, mode 0) -> count = preset_input, tpulse stays 0. Asynchronous reset asserted mid-count (count = 128) -> count_out = 0, tpulse = 0, running = 1 immediately, without waiting for a clk edge.
